// File: rtl/fmul64_lsh_round_stage.sv
// Two-stage round pipeline for the F64 multiplier subnormal (lsh) path:
// extracts ovf/L/G/S from the shifted product, selects the fraction and rounds.
module fmul64_lsh_round_stage #(
  parameter int SIG_W  = 106,
  parameter int FRAC_W = 52
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [SIG_W-1:0]  sig_mul_i,
  input  logic [5:0]        lsh_num_i,
  input  logic              sign_i,
  input  logic [2:0]        rm_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o,
  output logic              ovf_o,
  output logic              inexact_o
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic              s1_valid_q, s1_valid_d;
  logic [SIG_W-1:0]  s1_sig_q;
  logic [5:0]        s1_lsh_q;
  logic              s1_sign_q;
  logic [2:0]        s1_rm_q;

  logic              s2_valid_q, s2_valid_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              inexact_q, inexact_d;

  logic              out_xfer, s2_load, s1_adv, accept;
  logic [5:0]        lsh_clamped;
  logic [SIG_W-1:0]  sig_sh;
  logic [FRAC_W-1:0] frac_sel;
  logic              bit_l, bit_g, bit_s, inc;
  logic [FRAC_W:0]   sum;

  assign out_xfer = s2_valid_q & ready_i;
  assign s2_load  = ~s2_valid_q | ready_i;
  assign s1_adv   = s1_valid_q & s2_load;
  assign ready_o  = ~s1_valid_q | s1_adv;
  assign accept   = valid_i & ready_o & ~flush_i;

  assign lsh_clamped = (lsh_num_i > 6'd52) ? 6'd52 : lsh_num_i;

  // Left-shifting by n aligns sig_mul[105-n] to bit 105 and zero-fills below index 0.
  assign sig_sh = s1_sig_q << s1_lsh_q;

  always_comb begin
    ovf_d    = sig_sh[SIG_W-1];
    frac_sel = sig_sh[103:52];
    bit_l    = sig_sh[52];
    bit_g    = sig_sh[51];
    bit_s    = |sig_sh[50:0];
    if (ovf_d) begin
      frac_sel = sig_sh[104:53];
      bit_l    = sig_sh[53];
      bit_g    = sig_sh[52];
      bit_s    = |sig_sh[51:0];
    end
  end

  always_comb begin
    inc = bit_g & (bit_l | bit_s);
    case (s1_rm_q)
      RM_RNE:  inc = bit_g & (bit_l | bit_s);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign_q & (bit_g | bit_s);
      RM_RUP:  inc = ~s1_sign_q & (bit_g | bit_s);
      RM_RMM:  inc = bit_g;
      default: inc = bit_g & (bit_l | bit_s);
    endcase
  end

  assign sum       = {1'b0, frac_sel} + {{FRAC_W{1'b0}}, inc};
  assign frac_d    = sum[FRAC_W-1:0];
  assign carry_d   = sum[FRAC_W];
  assign inexact_d = bit_g | bit_s;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)
        s1_valid_d = 1'b1;
      else if (s1_adv)
        s1_valid_d = 1'b0;
      if (s1_adv)
        s2_valid_d = 1'b1;
      else if (out_xfer)
        s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sig_q  <= '0;
      s1_lsh_q  <= '0;
      s1_sign_q <= 1'b0;
      s1_rm_q   <= '0;
    end else if (accept) begin
      s1_sig_q  <= sig_mul_i;
      s1_lsh_q  <= lsh_clamped;
      s1_sign_q <= sign_i;
      s1_rm_q   <= rm_i;
    end
  end

  // Output registers only move on advance, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_q    <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else if (s1_adv && !flush_i) begin
      frac_q    <= frac_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
    end
  end

  assign valid_o   = s2_valid_q;
  assign frac_o    = frac_q;
  assign carry_o   = carry_q;
  assign ovf_o     = ovf_q;
  assign inexact_o = inexact_q;

endmodule

// File: tb/tb_fmul64_lsh_round_stage.sv
// Scoreboard bench for fmul64_lsh_round_stage: expected results are queued at
// accept time and compared whenever valid_o is high.
module tb_fmul64_lsh_round_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i, valid_i, ready_o, sign_i, valid_o, ready_i;
  logic [105:0] sig_mul_i;
  logic [5:0]   lsh_num_i;
  logic [2:0]   rm_i;
  logic [51:0]  frac_o;
  logic         carry_o, ovf_o, inexact_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [54:0] exp_q[$];

  localparam logic [51:0] ONES52 = {52{1'b1}};

  fmul64_lsh_round_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .sig_mul_i(sig_mul_i), .lsh_num_i(lsh_num_i), .sign_i(sign_i), .rm_i(rm_i),
    .valid_o(valid_o), .ready_i(ready_i), .frac_o(frac_o), .carry_o(carry_o),
    .ovf_o(ovf_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Result packing: {carry, ovf, inexact, frac}
  function automatic logic [54:0] pack(logic c, logic o, logic ix, logic [51:0] f);
    return {c, o, ix, f};
  endfunction

  function automatic logic bit_at(logic [105:0] s, int idx);
    if (idx < 0) return 1'b0;
    return s[idx];
  endfunction

  function automatic logic [54:0] model(logic [105:0] s, logic [5:0] l, logic sg, logic [2:0] rm);
    int n, lo;
    logic ov, lb, gb, sb, inc;
    logic [51:0] f;
    logic [52:0] sum;
    n  = (l > 6'd52) ? 52 : int'(l);
    ov = s[105-n];
    lo = ov ? (53 - n) : (52 - n);
    for (int i = 0; i < 52; i++) f[i] = bit_at(s, lo + i);
    lb = bit_at(s, lo);
    gb = bit_at(s, lo - 1);
    sb = 1'b0;
    for (int i = 0; i < lo - 1; i++) sb = sb | s[i];
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sg & (gb | sb);
      3'd3:    inc = ~sg & (gb | sb);
      3'd4:    inc = gb;
      default: inc = gb & (lb | sb);
    endcase
    sum = {1'b0, f} + 53'(inc);
    return pack(sum[52], ov, gb | sb, sum[51:0]);
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_o", 64'(valid_o), 64'd0);
      end else begin
        check("result", 64'(pack(carry_o, ovf_o, inexact_o, frac_o)), 64'(exp_q[0]));
        if (ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [105:0] s, input logic [5:0] l, input logic sg,
                      input logic [2:0] rm, input logic [54:0] exp);
    bit accepted = 0;
    valid_i = 1'b1; sig_mul_i = s; lsh_num_i = l; sign_i = sg; rm_i = rm;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (ready_o && !flush_i) begin
        exp_q.push_back(exp);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    if (!accepted) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Single op with ready_i high, also checking the two-edge latency.
  task automatic directed(input logic [105:0] s, input logic [5:0] l, input logic sg,
                          input logic [2:0] rm, input logic [54:0] exp);
    send(s, l, sg, rm, exp);
    idle();
    @(negedge clk); check("lat_edge1", 64'(valid_o), 64'd0);
    @(negedge clk); check("lat_edge2", 64'(valid_o), 64'd1);
    @(posedge clk); #1;
  endtask

  logic [105:0] carry_sig, max_sig, rs;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sig_mul_i = '0; lsh_num_i = '0; sign_i = 1'b0; rm_i = '0;
    #3;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_data", 64'(pack(carry_o, ovf_o, inexact_o, frac_o)), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    directed(106'd1 << 105, 6'd0, 1'b0, 3'd0, pack(1'b0, 1'b1, 1'b0, 52'd0));

    carry_sig = (106'd1 << 104) | (106'(ONES52) << 52) | (106'd1 << 51);
    directed(carry_sig, 6'd0, 1'b0, 3'd0, pack(1'b1, 1'b0, 1'b1, 52'd0));
    directed(carry_sig, 6'd0, 1'b0, 3'd1, pack(1'b0, 1'b0, 1'b1, ONES52));

    max_sig = (106'd1 << 53) | 106'd1;
    directed(max_sig, 6'd52, 1'b0, 3'd0, pack(1'b0, 1'b1, 1'b1, 52'd0));
    directed(max_sig, 6'd52, 1'b0, 3'd3, pack(1'b0, 1'b1, 1'b1, 52'd1));
    directed(max_sig, 6'd52, 1'b0, 3'd2, pack(1'b0, 1'b1, 1'b1, 52'd0));
    directed(max_sig, 6'd60, 1'b0, 3'd0, pack(1'b0, 1'b1, 1'b1, 52'd0));
    directed(max_sig, 6'd60, 1'b0, 3'd3, pack(1'b0, 1'b1, 1'b1, 52'd1));
    directed(max_sig, 6'd52, 1'b1, 3'd2, pack(1'b0, 1'b1, 1'b1, 52'd1));
    directed(max_sig, 6'd52, 1'b0, 3'd4, pack(1'b0, 1'b1, 1'b1, 52'd1));
    drain();

    // Backpressure: four back-to-back ops, ready_i low for four cycles.
    fork
      begin
        send(106'd1 << 105, 6'd0, 1'b0, 3'd0, pack(1'b0, 1'b1, 1'b0, 52'd0));
        send(carry_sig, 6'd0, 1'b0, 3'd0, pack(1'b1, 1'b0, 1'b1, 52'd0));
        send(carry_sig, 6'd0, 1'b0, 3'd1, pack(1'b0, 1'b0, 1'b1, ONES52));
        send(max_sig, 6'd52, 1'b0, 3'd3, pack(1'b0, 1'b1, 1'b1, 52'd1));
        idle();
      end
      begin
        @(posedge clk); #1; ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_o_low", 64'(ready_o), 64'd0);
        check("bp_valid_o_high", 64'(valid_o), 64'd1);
        repeat (3) @(posedge clk);
        #1; ready_i = 1'b1;
      end
    join
    drain();

    // Flush with both stages full and a new op presented.
    ready_i = 1'b0;
    send(carry_sig, 6'd0, 1'b0, 3'd1, pack(1'b0, 1'b0, 1'b1, ONES52));
    send(max_sig, 6'd52, 1'b0, 3'd0, pack(1'b0, 1'b1, 1'b1, 52'd0));
    @(negedge clk);
    check("fl_ready_o_full", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    valid_i = 1'b1; sig_mul_i = 106'd1 << 105; flush_i = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    flush_i = 1'b0; idle(); ready_i = 1'b1;
    @(negedge clk);
    check("fl_valid_o", 64'(valid_o), 64'd0);
    check("fl_ready_o", 64'(ready_o), 64'd1);
    repeat (4) @(posedge clk);
    #1;

    // Random stream with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rs = {$urandom(), $urandom(), $urandom(), 10'($urandom())};
          if (i % 3 == 0) rs = rs >> $urandom_range(0, 60);
          lsh_num_i = 6'($urandom_range(0, 63));
          sign_i = 1'($urandom_range(0, 1));
          rm_i = 3'($urandom_range(0, 7));
          send(rs, lsh_num_i, sign_i, rm_i, model(rs, lsh_num_i, sign_i, rm_i));
          if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
        end
        idle();
      end
      begin
        for (int c = 0; c < 150; c++) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 2) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // Asynchronous reset while a result is being presented.
    send(carry_sig, 6'd0, 1'b0, 3'd1, pack(1'b0, 1'b0, 1'b1, ONES52));
    idle();
    @(posedge clk); #2;
    check("pre_rst_valid_o", 64'(valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", 64'(valid_o), 64'd0);
    check("async_rst_data", 64'(pack(carry_o, ovf_o, inexact_o, frac_o)), 64'd0);
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid_o", 64'(valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
